// File: rtl/booth4_multiplier_fp32.sv
// Iterative radix-4 Booth multiplier for IEEE-754 binary32 operands.
// One Booth digit per clock into a shift-add accumulator, then normalize, round RNE and pack.
module booth4_multiplier_fp32 #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned BIAS   = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [2:0]  exc_flags
);

  localparam int unsigned FRAC_W  = MANT_W - 1;
  localparam int unsigned E_W     = EXP_W + 2;
  localparam int unsigned ACC_W   = MANT_W + 3;
  localparam int unsigned LO_W    = MANT_W + 2;
  localparam int unsigned VEC_W   = MANT_W + 3;
  localparam int unsigned P_W     = 2 * MANT_W;
  localparam int unsigned HI_KEEP = P_W - LO_W;
  localparam int unsigned DIGITS  = (MANT_W + 2) / 2;
  localparam int unsigned CNT_W   = 4;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [E_W-1:0]   E_INF    = E_W'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t               state, state_next;
  special_t             special, special_c;
  logic                 sign;
  logic [E_W-1:0]       exp_sum;
  logic [MANT_W-1:0]    ma;
  logic [VEC_W-1:0]     vec;
  logic [ACC_W-1:0]     acc_hi;
  logic [LO_W-1:0]      acc_lo;
  logic [CNT_W-1:0]     cnt;

  // Operand decode and special-case classification
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [MANT_W-1:0] ma_in, mb_in;

  assign ea     = a[FRAC_W +: EXP_W];
  assign eb     = b[FRAC_W +: EXP_W];
  assign fa     = a[FRAC_W-1:0];
  assign fb     = b[FRAC_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign ma_in  = a_zero ? '0 : {1'b1, fa};
  assign mb_in  = b_zero ? '0 : {1'b1, fb};

  always_comb begin
    special_c = SP_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) special_c = SP_NAN;
    else if (a_inf || b_inf)                                      special_c = SP_INF;
    else if (a_zero || b_zero)                                    special_c = SP_ZERO;
  end

  // Booth digit selection and partial product
  logic [ACC_W-1:0] mag, pp, sum;
  logic             neg;

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (vec[2:0])
      3'b001, 3'b010: mag = ACC_W'(ma);
      3'b011:         mag = ACC_W'({ma, 1'b0});
      3'b100:         begin mag = ACC_W'({ma, 1'b0}); neg = 1'b1; end
      3'b101, 3'b110: begin mag = ACC_W'(ma);         neg = 1'b1; end
      default:        ;
    endcase
    pp  = neg ? (~mag + ACC_W'(1)) : mag;
    sum = acc_hi + pp;
  end

  // Normalize, round to nearest even, range check, special override
  logic [P_W-1:0]    prod;
  logic              norm_hi, g, s, inc;
  logic [FRAC_W-1:0] m, frac_fin;
  logic [FRAC_W:0]   m_round;
  logic [E_W-1:0]    e_pre, e_fin;
  logic [31:0]       res_c;
  logic [2:0]        flags_c;

  always_comb begin
    prod     = {acc_hi[HI_KEEP-1:0], acc_lo};
    norm_hi  = prod[P_W-1];
    m        = norm_hi ? prod[P_W-2 -: FRAC_W] : prod[P_W-3 -: FRAC_W];
    g        = norm_hi ? prod[P_W-2-FRAC_W] : prod[P_W-3-FRAC_W];
    s        = norm_hi ? |prod[P_W-3-FRAC_W:0] : |prod[P_W-4-FRAC_W:0];
    e_pre    = exp_sum + E_W'(norm_hi);
    inc      = g & (s | m[0]);
    m_round  = {1'b0, m} + (FRAC_W+1)'(inc);
    e_fin    = e_pre + E_W'(m_round[FRAC_W]);
    frac_fin = m_round[FRAC_W-1:0];
    res_c    = {sign, e_fin[EXP_W-1:0], frac_fin};
    flags_c  = 3'b000;
    if (e_fin[E_W-1] || (e_fin == '0)) begin
      res_c   = {sign, (EXP_W+FRAC_W)'(0)};
      flags_c = 3'b001;
    end else if (e_fin >= E_INF) begin
      res_c   = {sign, EXP_ONES, FRAC_W'(0)};
      flags_c = 3'b010;
    end
    case (special)
      SP_NAN:  begin res_c = {1'b0, EXP_ONES, 1'b1, (FRAC_W-1)'(0)}; flags_c = 3'b100; end
      SP_INF:  begin res_c = {sign, EXP_ONES, FRAC_W'(0)};           flags_c = 3'b000; end
      SP_ZERO: begin res_c = {sign, (EXP_W+FRAC_W)'(0)};             flags_c = 3'b000; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == CNT_W'(DIGITS - 1)) state_next = NORM;
      NORM:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      exc_flags    <= '0;
      sign         <= 1'b0;
      exp_sum      <= '0;
      ma           <= '0;
      vec          <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      cnt          <= '0;
      special      <= SP_NONE;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy    <= 1'b1;
          sign    <= a[31] ^ b[31];
          exp_sum <= E_W'(ea) + E_W'(eb) - E_W'(BIAS);
          ma      <= ma_in;
          vec     <= {2'b00, mb_in, 1'b0};
          acc_hi  <= '0;
          acc_lo  <= '0;
          cnt     <= '0;
          special <= special_c;
        end
        CALC: begin
          // Arithmetic shift by one radix-4 digit; retired bits drop into the low word
          acc_hi <= {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
          acc_lo <= {sum[1:0], acc_lo[LO_W-1:2]};
          vec    <= {2'b00, vec[VEC_W-1:2]};
          cnt    <= cnt + CNT_W'(1);
        end
        NORM: begin
          result       <= res_c;
          exc_flags    <= flags_c;
          result_valid <= 1'b1;
        end
        DONE: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_multiplier_fp32.sv
// Self-checking bench for booth4_multiplier_fp32: directed corner cases, handshake
// timing, abort-by-reset and randomized operands against a real-arithmetic model.
module tb_booth4_multiplier_fp32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic [2:0]  exc_flags;

  int n_checks = 0;
  int n_fail   = 0;

  booth4_multiplier_fp32 dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .result(result), .result_valid(result_valid), .exc_flags(exc_flags)
  );

  always #5 clk = ~clk;

  // Magnitude of a normal binary32 value as a real
  function automatic real to_real(input logic [31:0] x);
    real m;
    m = 1.0 + real'(int'(x[22:0])) / 8388608.0;
    return m * (2.0 ** (real'(int'(x[30:23])) - 127.0));
  endfunction

  // Reference: exact product in double precision, rounded RNE to 24 bits, flush/saturate
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] f);
    logic sgn;
    bit   xz, yz, xi, yi, xn, yn;
    real  p, sc, rem;
    int   e, be, n;
    sgn = x[31] ^ y[31];
    xz = (x[30:23] == 8'h00); yz = (y[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    f = 3'b000;
    if (xn || yn || (xi && yz) || (yi && xz)) begin
      r = 32'h7FC00000; f = 3'b100;
    end else if (xi || yi) begin
      r = {sgn, 31'h7F800000};
    end else if (xz || yz) begin
      r = {sgn, 31'h0};
    end else begin
      p = to_real(x) * to_real(y);
      e = 0;
      while (p >= 2.0) begin p = p / 2.0; e++; end
      while (p < 1.0)  begin p = p * 2.0; e--; end
      sc  = p * 8388608.0;
      n   = $rtoi(sc);
      rem = sc - real'(n);
      if (rem > 0.5 || (rem == 0.5 && n[0])) n++;
      if (n == 16777216) begin n = 8388608; e++; end
      be = e + 127;
      if (be >= 255) begin
        r = {sgn, 31'h7F800000}; f = 3'b010;
      end else if (be <= 0) begin
        r = {sgn, 31'h0}; f = 3'b001;
      end else begin
        r = {sgn, 8'(be), 23'(n)};
      end
    end
  endfunction

  function automatic logic [31:0] rand_normal(input bit narrow);
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = narrow ? 8'($urandom_range(64, 190)) : 8'($urandom_range(1, 254));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  // Launch one operation and wait for its valid pulse, then step one more edge
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input int inj_at, input logic [31:0] ix, input logic [31:0] iy,
                        input bit junk_at_done,
                        output logic [31:0] r, output logic [2:0] f, output int lat,
                        output logic busy_e0, output logic post_valid, output logic post_busy);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    busy_e0 = busy;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; r = '0; f = '0;
    for (int i = 1; i <= 40; i++) begin
      if (i == inj_at) begin start = 1'b1; a = ix; b = iy; end
      @(posedge clk); #1;
      if (i == inj_at) start = 1'b0;
      if (result_valid) begin lat = i; r = result; f = exc_flags; break; end
    end
    if (junk_at_done) begin start = 1'b1; a = $urandom; b = $urandom; end
    @(posedge clk); #1;
    post_valid = result_valid;
    post_busy  = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (result !== 32'h0)   begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", result); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    n_checks++; if (exc_flags !== 3'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", exc_flags); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] x, y, r;
    logic [2:0]  f;
  } vec_t;

  task automatic test_directed;
    vec_t        tv[9];
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    logic        be0, pv, pb;
    tv[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000};
    tv[1] = '{32'h40400000, 32'hC0400000, 32'hC1100000, 3'b000};
    tv[2] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
    tv[3] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010};
    tv[4] = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001};
    tv[5] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100};
    tv[6] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
    tv[7] = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000};
    tv[8] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100};
    foreach (tv[k]) begin
      run_op(tv[k].x, tv[k].y, 0, 32'h0, 32'h0, 1'b0, r, f, lat, be0, pv, pb);
      n_checks++; if (r !== tv[k].r) begin n_fail++; $display("FAIL dir%0d_result: %h*%h got %h expected %h", k, tv[k].x, tv[k].y, r, tv[k].r); end
      n_checks++; if (f !== tv[k].f) begin n_fail++; $display("FAIL dir%0d_flags: got %b expected %b", k, f, tv[k].f); end
      n_checks++; if (lat !== 14)    begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected 14", k, lat); end
      n_checks++; if (be0 !== 1'b1)  begin n_fail++; $display("FAIL dir%0d_busy_after_start: got %b expected 1", k, be0); end
      n_checks++; if (pv !== 1'b0)   begin n_fail++; $display("FAIL dir%0d_valid_pulse_width: got %b expected 0", k, pv); end
      n_checks++; if (pb !== 1'b0)   begin n_fail++; $display("FAIL dir%0d_busy_after_done: got %b expected 0", k, pb); end
    end
  endtask

  task automatic test_ignore_restart;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    logic        be0, pv, pb, seen;
    run_op(32'h40400000, 32'hC0400000, 5, 32'h3FC00000, 32'h40000000, 1'b0, r, f, lat, be0, pv, pb);
    n_checks++; if (r !== 32'hC1100000) begin n_fail++; $display("FAIL restart_result: got %h expected c1100000", r); end
    n_checks++; if (lat !== 14)         begin n_fail++; $display("FAIL restart_latency: got %0d expected 14", lat); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (result_valid || busy) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL restart_spurious_op: got %b expected 0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r, er;
    logic [2:0]  f, ef;
    int          lat;
    logic        be0, pv, pb;
    run_op(32'h40A00000, 32'h40E00000, 0, 32'h0, 32'h0, 1'b1, r, f, lat, be0, pv, pb);
    n_checks++; if (r !== 32'h420C0000) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 420c0000", r); end
    n_checks++; if (pb !== 1'b0)        begin n_fail++; $display("FAIL b2b_busy_at_done: got %b expected 0", pb); end
    ref_mul(32'hBFC00000, 32'h41200000, er, ef);
    run_op(32'hBFC00000, 32'h41200000, 0, 32'h0, 32'h0, 1'b0, r, f, lat, be0, pv, pb);
    n_checks++; if (r !== er)    begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", r, er); end
    n_checks++; if (lat !== 14)  begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 14", lat); end
    n_checks++; if (be0 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_at_e16: got %b expected 1", be0); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] r, er;
    logic [2:0]  f, ef;
    int          lat;
    logic        be0, pv, pb, seen;
    @(negedge clk);
    a = 32'h40400000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (result !== 32'h0)      begin n_fail++; $display("FAIL abort_result: got %h expected 00000000", result); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", result_valid); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin @(negedge clk); rst = 1'b1; end
      @(posedge clk); #1;
      if (result_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_pulse: got %b expected 0", seen); end
    ref_mul(32'h3FC00000, 32'h40400000, er, ef);
    run_op(32'h3FC00000, 32'h40400000, 0, 32'h0, 32'h0, 1'b0, r, f, lat, be0, pv, pb);
    n_checks++; if (r !== er)   begin n_fail++; $display("FAIL abort_next_result: got %h expected %h", r, er); end
    n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected 14", lat); end
  endtask

  task automatic test_random(input int n_ops, input bit ties);
    logic [31:0] x, y, r, er, t;
    logic [2:0]  f, ef;
    int          lat;
    logic        be0, pv, pb;
    for (int k = 0; k < n_ops; k++) begin
      if (ties) begin
        // 1.5 * (1 + odd/2^23) leaves exactly half an ulp below the kept bits
        x = {1'($urandom_range(0, 1)), 8'($urandom_range(80, 170)), 23'h400000};
        y = {1'($urandom_range(0, 1)), 8'($urandom_range(80, 170)),
             23'($urandom_range(0, 32'h2AAAA9)) | 23'h1};
        if ($urandom_range(0, 1) == 1) begin t = x; x = y; y = t; end
      end else begin
        x = rand_normal($urandom_range(0, 3) != 0);
        y = rand_normal($urandom_range(0, 3) != 0);
      end
      ref_mul(x, y, er, ef);
      run_op(x, y, 0, 32'h0, 32'h0, 1'b0, r, f, lat, be0, pv, pb);
      n_checks++; if (r !== er)   begin n_fail++; $display("FAIL rand_result: %h*%h got %h expected %h", x, y, r, er); end
      n_checks++; if (f !== ef)   begin n_fail++; $display("FAIL rand_flags: %h*%h got %b expected %b", x, y, f, ef); end
      n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL rand_latency: %h*%h got %0d expected 14", x, y, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_restart();
    test_back_to_back();
    test_reset_abort();
    test_random(2500, 1'b0);
    test_random(300, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
